// File: rtl/boss_bullet_ctrl.sv
// boss_bullet_ctrl: boss bullet spawner, mover and Reimu hit / life tracker.
//
// Spawns a bullet below the boss every FIRE_PERIOD cycles while bossE is high. Each active
// bullet falls BULLET_STEP px per cycle. Bullets overlapping Reimu's hit box cost one life
// per cycle, however many of them hit, and start an invincibility window. Losing the last
// life moves to a sticky game-over state.
//
// Optional feature: define AIMED_SHOT_EN to make each bullet drift sideways towards the side
// of the boss that Reimu was on when the bullet spawned.
//
// Ports:
//   clk_22      game clock
//   rst_n       asynchronous reset, active low
//   gamestart   synchronous clear to reset values
//   bossE       boss alive, firing allowed
//   bossx/bossy boss centre
//   reimux/y    Reimu centre
//   bulletx/y   packed bullet positions, slot i at [10i+9:10i]
//   bullet_act  per-slot active flags
//   reimu_hit   one-cycle pulse when a life is lost
//   reimu_inv   invincibility window active
//   reimu_life  remaining lives
//   game_over   lives exhausted, sticky until reset or gamestart
`timescale 1ns/1ps
module boss_bullet_ctrl #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned FIRE_PERIOD = 16,
  parameter int unsigned BULLET_STEP = 4,
  parameter int unsigned SPAWN_DY    = 38,
  parameter int unsigned HIT_R       = 6,
  parameter int unsigned INV_CYCLES  = 32,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic                      clk_22,
  input  logic                      rst_n,
  input  logic                      gamestart,
  input  logic                      bossE,
  input  logic [9:0]                bossx,
  input  logic [9:0]                bossy,
  input  logic [9:0]                reimux,
  input  logic [9:0]                reimuy,
  output logic [10*NUM_BULLETS-1:0] bulletx,
  output logic [10*NUM_BULLETS-1:0] bullety,
  output logic [NUM_BULLETS-1:0]    bullet_act,
  output logic                      reimu_hit,
  output logic                      reimu_inv,
  output logic [2:0]                reimu_life,
  output logic                      game_over
);

  localparam int unsigned FcW = (FIRE_PERIOD > 2) ? $clog2(FIRE_PERIOD) : 1;
  localparam int unsigned IcW = (INV_CYCLES > 2) ? $clog2(INV_CYCLES) : 1;

  localparam logic [FcW-1:0] FireReload = FcW'(FIRE_PERIOD - 1);
  localparam logic [IcW-1:0] InvReload  = IcW'(INV_CYCLES - 1);
  localparam logic [10:0]    StepY      = 11'(BULLET_STEP);
  localparam logic [10:0]    SpawnDy    = 11'(SPAWN_DY);
  localparam logic [10:0]    HitR       = 11'(HIT_R);
  localparam logic [10:0]    ScreenH    = 11'(SCREEN_H);
  localparam logic [2:0]     LifeInit   = 3'(LIVES_INIT);

  localparam logic [1:0] StRun  = 2'd0;
  localparam logic [1:0] StInv  = 2'd1;
  localparam logic [1:0] StOver = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [FcW-1:0]                fire_cnt_q, fire_cnt_d;
  logic [IcW-1:0]                inv_cnt_q, inv_cnt_d;
  logic [2:0]                    life_q, life_d;
  logic [NUM_BULLETS-1:0]        act_q, act_d;
  logic [NUM_BULLETS-1:0][9:0]   bx_q, bx_d;
  logic [NUM_BULLETS-1:0][9:0]   by_q, by_d;

  logic [NUM_BULLETS-1:0]        hit_vec;
  logic [NUM_BULLETS-1:0]        spawn_oh;
  logic [NUM_BULLETS-1:0]        out_vec;
  logic [NUM_BULLETS-1:0][10:0]  dx, dy, ny;
  logic [10:0]                   spawn_y;
  logic                          hit_any;
  logic                          fire_tick;

`ifdef AIMED_SHOT_EN
  localparam logic [11:0] StepX   = 12'(BULLET_STEP / 2);
  localparam logic [11:0] ScreenW = 12'(SCREEN_W);

  // Direction encoding: 01 = +1, 11 = -1, 00 = straight down.
  logic [NUM_BULLETS-1:0][1:0]  dir_q, dir_d;
  logic [NUM_BULLETS-1:0][11:0] nx;
  logic [1:0]                   spawn_dir;
`endif

  // Lowest clear bit of act_q: the slot a spawn lands in (zero when all slots are busy).
  assign spawn_oh  = ~act_q & (act_q + NUM_BULLETS'(1));
  assign spawn_y   = {1'b0, bossy} + SpawnDy;
  assign hit_any   = |hit_vec;
  assign fire_tick = (state_q != StOver) && bossE && (fire_cnt_q == '0);

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      dx[i] = (bx_q[i] >= reimux) ? ({1'b0, bx_q[i]} - {1'b0, reimux})
                                  : ({1'b0, reimux} - {1'b0, bx_q[i]});
      dy[i] = (by_q[i] >= reimuy) ? ({1'b0, by_q[i]} - {1'b0, reimuy})
                                  : ({1'b0, reimuy} - {1'b0, by_q[i]});
      ny[i] = {1'b0, by_q[i]} + StepY;
      hit_vec[i] = (state_q == StRun) && act_q[i] && (dx[i] <= HitR) && (dy[i] <= HitR);
    end
  end

`ifdef AIMED_SHOT_EN
  always_comb begin
    if (reimux > bossx) begin
      spawn_dir = 2'b01;
    end else if (reimux < bossx) begin
      spawn_dir = 2'b11;
    end else begin
      spawn_dir = 2'b00;
    end
    for (int i = 0; i < NUM_BULLETS; i++) begin
      case (dir_q[i])
        2'b01:   nx[i] = {2'b00, bx_q[i]} + StepX;
        2'b11:   nx[i] = {2'b00, bx_q[i]} - StepX;
        default: nx[i] = {2'b00, bx_q[i]};
      endcase
      // A negative result has bit 11 set, so the unsigned compare also catches it.
      out_vec[i] = (ny[i] >= ScreenH) || nx[i][11] || (nx[i] >= ScreenW);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      out_vec[i] = (ny[i] >= ScreenH);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    fire_cnt_d = fire_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    life_d     = life_q;
    act_d      = act_q;
    bx_d       = bx_q;
    by_d       = by_q;
`ifdef AIMED_SHOT_EN
    dir_d      = dir_q;
`endif

    if ((state_q != StOver) && bossE) begin
      fire_cnt_d = (fire_cnt_q == '0) ? FireReload : (fire_cnt_q - FcW'(1));
    end

    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (act_q[i]) begin
        if (hit_vec[i] || out_vec[i]) begin
          act_d[i] = 1'b0;
        end else begin
          by_d[i] = ny[i][9:0];
`ifdef AIMED_SHOT_EN
          bx_d[i] = nx[i][9:0];
`endif
        end
      end else if (fire_tick && spawn_oh[i]) begin
        act_d[i] = 1'b1;
        bx_d[i]  = bossx;
        by_d[i]  = spawn_y[9:0];
`ifdef AIMED_SHOT_EN
        dir_d[i] = spawn_dir;
`endif
      end
    end

    case (state_q)
      StRun: begin
        if (hit_any) begin
          life_d = life_q - 3'd1;
          if (life_q <= 3'd1) begin
            state_d = StOver;
            act_d   = '0;
          end else begin
            state_d   = StInv;
            inv_cnt_d = InvReload;
          end
        end
      end
      StInv: begin
        if (inv_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          inv_cnt_d = inv_cnt_q - IcW'(1);
        end
      end
      StOver: begin
        act_d = '0;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (gamestart) begin
      state_d    = StRun;
      fire_cnt_d = FireReload;
      inv_cnt_d  = '0;
      life_d     = LifeInit;
      act_d      = '0;
      bx_d       = '0;
      by_d       = '0;
`ifdef AIMED_SHOT_EN
      dir_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk_22 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fire_cnt_q <= FireReload;
      inv_cnt_q  <= '0;
      life_q     <= LifeInit;
      act_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
`ifdef AIMED_SHOT_EN
      dir_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fire_cnt_q <= fire_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      life_q     <= life_d;
      act_q      <= act_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
`ifdef AIMED_SHOT_EN
      dir_q      <= dir_d;
`endif
    end
  end

  always_comb begin
    bulletx = '0;
    bullety = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bulletx[10*i +: 10] = bx_q[i];
      bullety[10*i +: 10] = by_q[i];
    end
  end

  assign bullet_act = act_q;
  assign reimu_hit  = hit_any && !gamestart;
  assign reimu_inv  = (state_q == StInv);
  assign reimu_life = life_q;
  assign game_over  = (state_q == StOver);

endmodule
